// File: rtl/upscaler_pkg.sv
// Shared types and sizing helper for the line upscaler and its line buffers.
package upscaler_pkg;

    localparam int RGB_CHAN_BITS = 8;

    typedef struct packed {
        logic [RGB_CHAN_BITS-1:0] r;
        logic [RGB_CHAN_BITS-1:0] g;
        logic [RGB_CHAN_BITS-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } fill_state_t;

    function automatic int line_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Read latency 1 cycle; no backpressure, a write lands whenever wr_en_i is high.
module line_buffer
    import upscaler_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int WIDTH = 24
) (
    input  logic                         clk_in,
    input  logic                         wr_en_i,
    input  logic [line_idx_w(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]             wr_dat_i,
    input  logic [line_idx_w(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]             rd_dat_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk_in) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_dat_q <= mem_q[rd_addr_i];
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/line_upscaler.sv
// Nearest-neighbour upscaler: ping-pong line buffers filled through a line-pull handshake, 2-cycle pixel latency.
// src_ready_out is high only while filling; video timing is never stalled, late lines are drawn black.
module line_upscaler
    import upscaler_pkg::*;
#(
    parameter int SRC_WIDTH  = 320,
    parameter int SRC_HEIGHT = 180,
    parameter int SCALE_LOG2 = 2,
    parameter int COLOR_BITS = 8,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [10:0]                       hcount_in,
    input  logic [9:0]                        vcount_in,
    input  logic                              ad_in,
    input  logic                              nf_in,
    output logic                              line_req_out,
    output logic [line_idx_w(SRC_HEIGHT)-1:0] line_y_out,
    input  logic [3*COLOR_BITS-1:0]           src_data_in,
    input  logic                              src_valid_in,
    output logic                              src_ready_out,
    output logic [COLOR_BITS-1:0]             red_out,
    output logic [COLOR_BITS-1:0]             green_out,
    output logic [COLOR_BITS-1:0]             blue_out,
    output logic                              underrun_out
);

    localparam int AW = line_idx_w(SRC_WIDTH);
    localparam int LW = line_idx_w(SRC_HEIGHT);
    localparam int PW = 3 * COLOR_BITS;
    localparam logic [9:0] VMASK = 10'((1 << SCALE_LOG2) - 1);

    fill_state_t   state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [LW-1:0] line_y_q, line_y_d;
    logic [LW-1:0] pend_y_q, pend_y_d;
    logic [LW-1:0] disp_y_q, disp_y_d;
    logic [1:0]    full_q, full_d;
    logic          rd_sel_q, rd_sel_d;
    logic          first_q, first_d;
    logic          show_q, show_d;
    logic          pend_q, pend_d;
    logic          underrun_q, underrun_d;
    logic          ad_p1_q, gate_p1_q, sel_p1_q;
    logic [PW-1:0] rgb_q;

    logic          beat, last_beat, wr_en, swap, gate;
    logic [10:0]   src_x;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_dat0, rd_dat1;

    assign beat      = (state_q == FILL) && src_valid_in;
    assign last_beat = beat && (wr_addr_q == AW'(SRC_WIDTH - 1));
    assign wr_en     = beat && !nf_in;
    assign swap      = (hcount_in == 11'(H_ACTIVE - 1)) && (vcount_in < 10'(V_ACTIVE))
                    && ((vcount_in & VMASK) == VMASK);

    // Until the first swap of a frame there is no swap-time snapshot, so line 0 shows once it is full.
    assign gate    = first_q ? full_q[rd_sel_q] : show_q;
    assign src_x   = hcount_in >> SCALE_LOG2;
    assign rd_addr = (src_x < 11'(SRC_WIDTH)) ? src_x[AW-1:0] : '0;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        line_y_d   = line_y_q;
        pend_y_d   = pend_y_q;
        disp_y_d   = disp_y_q;
        full_d     = full_q;
        rd_sel_d   = rd_sel_q;
        first_d    = first_q;
        show_d     = show_q;
        pend_d     = pend_q;
        underrun_d = underrun_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d  = REQ;
                    line_y_d = pend_y_q;
                    pend_d   = 1'b0;
                end
            end
            REQ: state_d = FILL;
            FILL: begin
                if (beat) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (last_beat) begin
                        wr_addr_d            = '0;
                        full_d[line_y_q[0]]  = 1'b1;
                        state_d              = IDLE;
                        if (line_y_q == '0 && SRC_HEIGHT > 1) begin
                            state_d  = REQ;
                            line_y_d = LW'(1);
                        end else if (pend_q) begin
                            state_d  = REQ;
                            line_y_d = pend_y_q;
                            pend_d   = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (swap) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            first_d          = 1'b0;
            // Swapping away from the last source line just ends the frame; nothing is due.
            if (disp_y_q == LW'(SRC_HEIGHT - 1)) begin
                show_d = 1'b0;
            end else begin
                disp_y_d = disp_y_q + 1'b1;
                show_d   = full_d[!rd_sel_q];
                if (!full_d[!rd_sel_q]) begin
                    underrun_d = 1'b1;
                end
                if (int'(disp_y_q) + 2 < SRC_HEIGHT) begin
                    pend_d   = 1'b1;
                    pend_y_d = disp_y_q + LW'(2);
                end
            end
        end

        if (nf_in) begin
            state_d   = REQ;
            line_y_d  = '0;
            wr_addr_d = '0;
            full_d    = '0;
            rd_sel_d  = 1'b0;
            first_d   = 1'b1;
            show_d    = 1'b0;
            pend_d    = 1'b0;
            disp_y_d  = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            line_y_q   <= '0;
            pend_y_q   <= '0;
            disp_y_q   <= '0;
            full_q     <= '0;
            rd_sel_q   <= 1'b0;
            first_q    <= 1'b0;
            show_q     <= 1'b0;
            pend_q     <= 1'b0;
            underrun_q <= 1'b0;
            ad_p1_q    <= 1'b0;
            gate_p1_q  <= 1'b0;
            sel_p1_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            line_y_q   <= line_y_d;
            pend_y_q   <= pend_y_d;
            disp_y_q   <= disp_y_d;
            full_q     <= full_d;
            rd_sel_q   <= rd_sel_d;
            first_q    <= first_d;
            show_q     <= show_d;
            pend_q     <= pend_d;
            underrun_q <= underrun_d;
            ad_p1_q    <= ad_in;
            gate_p1_q  <= gate;
            sel_p1_q   <= rd_sel_q;
            rgb_q      <= (ad_p1_q && gate_p1_q) ? (sel_p1_q ? rd_dat1 : rd_dat0) : '0;
        end
    end

    line_buffer #(.DEPTH(SRC_WIDTH), .WIDTH(PW)) u_buf0 (
        .clk_in    (clk_in),
        .wr_en_i   (wr_en && !line_y_q[0]),
        .wr_addr_i (wr_addr_q),
        .wr_dat_i  (src_data_in),
        .rd_addr_i (rd_addr),
        .rd_dat_o  (rd_dat0)
    );

    line_buffer #(.DEPTH(SRC_WIDTH), .WIDTH(PW)) u_buf1 (
        .clk_in    (clk_in),
        .wr_en_i   (wr_en && line_y_q[0]),
        .wr_addr_i (wr_addr_q),
        .wr_dat_i  (src_data_in),
        .rd_addr_i (rd_addr),
        .rd_dat_o  (rd_dat1)
    );

    assign line_req_out  = (state_q == REQ);
    assign line_y_out    = line_y_q;
    assign src_ready_out = (state_q == FILL);
    assign red_out       = rgb_q[PW-1 -: COLOR_BITS];
    assign green_out     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign blue_out      = rgb_q[COLOR_BITS-1:0];
    assign underrun_out  = underrun_q;

endmodule

// File: tb/tb_line_upscaler.sv
// Directed bench for line_upscaler with an 8x4 source scaled 2x onto a 16x8 active window.
module tb_line_upscaler;
    import upscaler_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        ad_in, nf_in;
    logic        line_req_out;
    logic [1:0]  line_y_out;
    logic [23:0] src_data_in;
    logic        src_valid_in, src_ready_out;
    logic [7:0]  red_out, green_out, blue_out;
    logic        underrun_out;

    always #5 clk_in = ~clk_in;

    line_upscaler #(
        .SRC_WIDTH(8), .SRC_HEIGHT(4), .SCALE_LOG2(1),
        .COLOR_BITS(8), .H_ACTIVE(16), .V_ACTIVE(8)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .ad_in(ad_in), .nf_in(nf_in), .line_req_out(line_req_out), .line_y_out(line_y_out),
        .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(src_ready_out),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .underrun_out(underrun_out)
    );

    // Video timing: free-running generator (24x10 total) or manual values from the main sequence.
    logic        vid_en = 1'b0;
    logic [10:0] gen_h = 11'd0, man_h = 11'd0;
    logic [9:0]  gen_v = 10'd8, man_v = 10'd8;
    logic        man_ad = 1'b0, man_nf = 1'b0;

    assign hcount_in = vid_en ? gen_h : man_h;
    assign vcount_in = vid_en ? gen_v : man_v;
    assign ad_in     = vid_en ? (gen_h < 11'd16 && gen_v < 10'd8) : man_ad;
    assign nf_in     = vid_en ? (gen_h == 11'd0 && gen_v == 10'd8) : man_nf;

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (vid_en) begin
                if (gen_h == 11'd23) begin
                    gen_h = 11'd0;
                    gen_v = (gen_v == 10'd9) ? 10'd0 : gen_v + 10'd1;
                end else begin
                    gen_h = gen_h + 11'd1;
                end
            end
        end
    end

    function automatic logic [23:0] pix(input logic [7:0] val);
        rgb_t p;
        p.r = val;
        p.g = ~val;
        p.b = val ^ 8'h5A;
        return p;
    endfunction

    // Line source: answers each request with 8 pixels of value (y<<4)|x.
    logic       src_en = 1'b0, junk_en = 1'b0, stall_en = 1'b0;
    logic       src_act = 1'b0, s_fire, s_req, s_rst;
    logic [1:0] src_y = 2'd0, s_ry;
    int         src_x = 0;

    initial begin
        src_valid_in = 1'b0;
        src_data_in  = '0;
        forever begin
            @(posedge clk_in);
            s_fire = src_valid_in && src_ready_out;
            s_req  = line_req_out;
            s_ry   = line_y_out;
            s_rst  = rst_in;
            #1;
            if (s_rst) begin
                src_act = 1'b0;
            end else begin
                if (s_fire) begin
                    src_x = src_x + 1;
                    if (src_x == 8) src_act = 1'b0;
                end
                if (s_req) begin
                    src_y   = s_ry;
                    src_x   = 0;
                    src_act = 1'b1;
                end
            end
            if (src_act) begin
                src_valid_in = src_en && !(stall_en && src_y == 2'd2 && gen_v < 10'd4);
                src_data_in  = pix({2'b00, src_y, 4'(src_x)});
            end else begin
                src_valid_in = junk_en;
                src_data_in  = 24'hC3C3C3;
            end
        end
    end

    logic [10:0] h_s1 = '0, h_s2 = '0;
    logic [9:0]  v_s1 = '0, v_s2 = '0;
    always @(posedge clk_in) begin
        h_s1 <= hcount_in;
        h_s2 <= h_s1;
        v_s1 <= vcount_in;
        v_s2 <= v_s1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, red_out, green_out, blue_out};
    endfunction

    task automatic wait_req(output logic got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (line_req_out) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [7:0] val;
        bit         blk_n;
        bit         blk_s;
    } vec_t;
    vec_t tbl[12];

    task automatic run_table(input bit stalled);
        logic ok;
        logic [31:0] exp;
        for (int i = 0; i < 12; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk_in);
                if (h_s2 == 11'(tbl[i].h) && v_s2 == 10'(tbl[i].v)) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk($sformatf("frame_timeout_%0d", i), 32'd0, 32'd1);
            end else begin
                exp = (stalled ? tbl[i].blk_s : tbl[i].blk_n) ? 32'd0 : {8'h00, pix(tbl[i].val)};
                chk($sformatf("pix_s%0d_h%0d_v%0d", stalled, tbl[i].h, tbl[i].v), rgb_now(), exp);
            end
        end
    endtask

    task automatic show_pix(input logic [10:0] h, input logic [9:0] v, input logic [31:0] exp,
                            input string name);
        man_h  = h;
        man_v  = v;
        man_ad = 1'b1;
        repeat (3) @(negedge clk_in);
        chk(name, rgb_now(), exp);
    endtask

    initial begin
        logic got;
        int   cnt;
        bit   seen;

        tbl[0]  = '{0,  0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2,  0, 8'h01, 1'b0, 1'b0};
        tbl[2]  = '{15, 0, 8'h07, 1'b0, 1'b0};
        tbl[3]  = '{16, 0, 8'h00, 1'b1, 1'b1};
        tbl[4]  = '{5,  1, 8'h02, 1'b0, 1'b0};
        tbl[5]  = '{0,  2, 8'h10, 1'b0, 1'b0};
        tbl[6]  = '{9,  3, 8'h14, 1'b0, 1'b0};
        tbl[7]  = '{4,  4, 8'h22, 1'b0, 1'b1};
        tbl[8]  = '{15, 5, 8'h27, 1'b0, 1'b1};
        tbl[9]  = '{6,  6, 8'h33, 1'b0, 1'b0};
        tbl[10] = '{15, 7, 8'h37, 1'b0, 1'b0};
        tbl[11] = '{20, 7, 8'h00, 1'b1, 1'b1};

        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_rgb", rgb_now(), 32'd0);
        chk("rst_ready", 32'(src_ready_out), 32'd0);
        chk("rst_req", 32'(line_req_out), 32'd0);
        chk("rst_line_y", 32'(line_y_out), 32'd0);
        chk("rst_underrun", 32'(underrun_out), 32'd0);
        rst_in = 1'b0;
        src_en = 1'b1;
        @(negedge clk_in);

        // New frame: line 0 request, exactly 8 beats, then line 1 request.
        vid_en = 1'b1;
        wait_req(got);
        chk("req0_seen", 32'(got), 32'd1);
        chk("req0_y", 32'(line_y_out), 32'd0);
        cnt  = 0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            if (src_ready_out) begin
                seen = 1;
                if (src_valid_in) cnt++;
            end else if (seen) begin
                break;
            end
        end
        chk("line0_beats", 32'(cnt), 32'd8);
        wait_req(got);
        chk("req1_seen", 32'(got), 32'd1);
        chk("req1_y", 32'(line_y_out), 32'd1);

        run_table(1'b0);
        chk("underrun_clean", 32'(underrun_out), 32'd0);
        stall_en = 1'b1;
        run_table(1'b1);
        chk("underrun_stall", 32'(underrun_out), 32'd1);
        stall_en = 1'b0;

        // Manual timing: valid offered while IDLE must neither be accepted nor written.
        vid_en = 1'b0;
        man_h  = 11'd0;
        man_v  = 10'd8;
        man_ad = 1'b0;
        man_nf = 1'b1;
        @(negedge clk_in);
        man_nf = 1'b0;
        repeat (30) @(negedge clk_in);
        src_en  = 1'b0;
        junk_en = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (src_ready_out) cnt++;
        end
        chk("idle_ready", 32'(cnt), 32'd0);
        junk_en = 1'b0;
        show_pix(11'd0, 10'd0, {8'h00, pix(8'h00)}, "rb_l0_h0");
        show_pix(11'd15, 10'd0, {8'h00, pix(8'h07)}, "rb_l0_h15");
        man_h = 11'd15;
        man_v = 10'd1;
        @(negedge clk_in);
        show_pix(11'd0, 10'd2, {8'h00, pix(8'h10)}, "rb_l1_h0");
        show_pix(11'd3, 10'd2, {8'h00, pix(8'h11)}, "rb_l1_h3");

        // nf coinciding with the last beat of line 0: line discarded, fresh request for line 0.
        man_ad = 1'b0;
        man_h  = 11'd0;
        man_v  = 10'd8;
        src_en = 1'b1;
        man_nf = 1'b1;
        @(negedge clk_in);
        man_nf = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (src_valid_in && src_ready_out && src_x == 7) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        chk("beat7_found", 32'(got), 32'd1);
        man_nf = 1'b1;
        @(negedge clk_in);
        man_nf = 1'b0;
        src_en = 1'b0;
        wait_req(got);
        chk("abort_req_seen", 32'(got), 32'd1);
        chk("abort_req_y", 32'(line_y_out), 32'd0);
        @(negedge clk_in);
        chk("abort_filling", 32'(src_ready_out), 32'd1);
        show_pix(11'd4, 10'd0, 32'd0, "abort_black");

        // Reset landing on beat 3 of a fill.
        man_ad = 1'b0;
        src_en = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (src_valid_in && src_ready_out && src_x == 3) begin
                got = 1'b1;
                break;
            end
        end
        chk("beat3_found", 32'(got), 32'd1);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("mid_rst_ready", 32'(src_ready_out), 32'd0);
        chk("mid_rst_rgb", rgb_now(), 32'd0);
        chk("mid_rst_underrun", 32'(underrun_out), 32'd0);
        rst_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
